// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- central pipeline control for the five-stage openMIPS core.
//
// Merges the ID load-use stall and the EX stall requests. Sequences
// multi-cycle EX operations with a countdown. Schedules one-cycle flushes
// that carry a redirect PC.
//
// Ports:
//   clk, rst_      core clock, asynchronous active-low reset
//   id_stallreq    ID load-use hazard stall request (current cycle)
//   ex_stallreq    EX generic stall request (current cycle)
//   ex_mc_start    one-cycle pulse, EX begins a multi-cycle op
//   ex_mc_cycles   total stall cycles of that op, sampled with ex_mc_start
//   flush_req      flush request, highest priority
//   flush_pc       redirect target, sampled with flush_req
//   stall[5:0]     hold bits: PC, IF, ID, EX, MEM, WB (bit0..bit5)
//   flush          registered one-cycle flush pulse
//   new_pc         redirect PC, valid while flush=1, held otherwise
//   mc_busy        high while a multi-cycle op is being counted down
//
// Optional: define PIPE_CTRL_STALL_CNT_EN to add stall_cycles[31:0].
//   It is a saturating count of the cycles with stall[0]=1, and reads 0
//   in any cycle where flush=1.
module pipe_ctrl #(
  parameter int CNT_W = 6,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             id_stallreq,
  input  logic             ex_stallreq,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_cycles,
  input  logic             flush_req,
  input  logic [PC_W-1:0]  flush_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [PC_W-1:0]  new_pc,
  output logic             mc_busy
`ifdef PIPE_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  typedef enum logic [1:0] {RUN = 2'd0, MCYC = 2'd1, FLUSH = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  new_pc_q, new_pc_d;
  logic             mc_start_run;

  // A start pulse with a nonzero length stalls in its own cycle.
  // Only ops longer than one cycle need the MCYC state.
  assign mc_start_run = (state_q == RUN) && ex_mc_start && (ex_mc_cycles != '0);

  // State register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_q;
    if (flush_req) begin
      // A flush wins from every state. It aborts any op in flight.
      state_d  = FLUSH;
      cnt_d    = '0;
      new_pc_d = flush_pc;
    end else begin
      case (state_q)
        RUN: begin
          // The start cycle counts as stall cycle 1. MCYC holds for the
          // remaining N-1 cycles, so the countdown is loaded with N-2.
          if (ex_mc_start && (ex_mc_cycles > CNT_W'(1))) begin
            cnt_d   = ex_mc_cycles - CNT_W'(2);
            state_d = MCYC;
          end
        end
        MCYC: begin
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Outputs
  always_comb begin
    stall = 6'b000000;
    // Reset forces stall low even though stall is combinational.
    // A flush, or the FLUSH state itself, releases every stage.
    if (!rst_ || flush_req || state_q == FLUSH)
      stall = 6'b000000;
    else if (state_q == MCYC || mc_start_run || ex_stallreq)
      stall = 6'b001111;
    else if (id_stallreq)
      stall = 6'b000111;
  end

  assign flush   = (state_q == FLUSH);
  assign mc_busy = (state_q == MCYC);
  assign new_pc  = new_pc_q;

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Clearing on an accepted flush request makes the count read 0 in the
  // cycle where flush=1.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush_req)
      stall_cnt_d = '0;
    else if (stall[0] && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed bench for pipe_ctrl.
// A vector table covers the single-cycle stall/flush priorities.
// Hand-written sequences cover the multi-cycle, abort, back-to-back
// flush, mid-op reset and (optionally) the stall counter.
module tb_pipe_ctrl;
  localparam int CNT_W = 6;
  localparam int PC_W  = 32;

  logic             clk;
  logic             rst_;
  logic             id_stallreq, ex_stallreq, ex_mc_start, flush_req;
  logic [CNT_W-1:0] ex_mc_cycles;
  logic [PC_W-1:0]  flush_pc;
  logic [5:0]       stall;
  logic             flush, mc_busy;
  logic [PC_W-1:0]  new_pc;
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0]      stall_cycles;
`endif

  pipe_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
    .clk          (clk),
    .rst_         (rst_),
    .id_stallreq  (id_stallreq),
    .ex_stallreq  (ex_stallreq),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .mc_busy      (mc_busy)
`ifdef PIPE_CTRL_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic id, input logic ex, input logic mcs,
                       input logic [CNT_W-1:0] mcn, input logic fr,
                       input logic [PC_W-1:0] fpc);
    id_stallreq  = id;
    ex_stallreq  = ex;
    ex_mc_start  = mcs;
    ex_mc_cycles = mcn;
    flush_req    = fr;
    flush_pc     = fpc;
  endtask

  // Move to 1 time unit after the next rising edge. Drive inputs there,
  // then wait 1 more unit and sample.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [5:0] e_stall,
                         input logic e_flush, input logic e_busy,
                         input logic [31:0] e_pc);
    chk({tag, ".stall"},   32'(stall),   32'(e_stall));
    chk({tag, ".flush"},   32'(flush),   32'(e_flush));
    chk({tag, ".mc_busy"}, 32'(mc_busy), 32'(e_busy));
    chk({tag, ".new_pc"},  new_pc,       e_pc);
  endtask

  // Inputs applied in a cycle, and the outputs expected in that same cycle.
  typedef struct {
    logic             id, ex, mcs;
    logic [CNT_W-1:0] mcn;
    logic             fr;
    logic [31:0]      fpc;
    logic [5:0]       e_stall;
    logic             e_flush, e_busy;
    logic [31:0]      e_pc;
  } vec_t;

  vec_t vecs[14];

  initial begin
    //          id ex  mcs mcn fr  fpc    stall      flush busy  pc
    vecs[0]  = '{0, 0, 0, 6'd0, 0, 32'h0,  6'b000000, 0, 0, 32'h0};
    vecs[1]  = '{1, 0, 0, 6'd0, 0, 32'h0,  6'b000111, 0, 0, 32'h0};
    vecs[2]  = '{0, 1, 0, 6'd0, 0, 32'h0,  6'b001111, 0, 0, 32'h0};
    vecs[3]  = '{1, 1, 0, 6'd0, 0, 32'h0,  6'b001111, 0, 0, 32'h0};
    vecs[4]  = '{0, 0, 1, 6'd0, 0, 32'h0,  6'b000000, 0, 0, 32'h0};
    vecs[5]  = '{1, 0, 1, 6'd0, 0, 32'h0,  6'b000111, 0, 0, 32'h0};
    vecs[6]  = '{0, 0, 1, 6'd1, 0, 32'h0,  6'b001111, 0, 0, 32'h0};
    vecs[7]  = '{0, 0, 0, 6'd0, 0, 32'h0,  6'b000000, 0, 0, 32'h0};
    vecs[8]  = '{1, 1, 0, 6'd0, 1, 32'h55, 6'b000000, 0, 0, 32'h0};
    vecs[9]  = '{1, 1, 0, 6'd0, 0, 32'h0,  6'b000000, 1, 0, 32'h55};
    vecs[10] = '{1, 0, 0, 6'd0, 0, 32'h0,  6'b000111, 0, 0, 32'h55};
    vecs[11] = '{0, 0, 1, 6'd1, 1, 32'h66, 6'b000000, 0, 0, 32'h55};
    vecs[12] = '{0, 0, 0, 6'd0, 0, 32'h0,  6'b000000, 1, 0, 32'h66};
    vecs[13] = '{0, 0, 0, 6'd0, 0, 32'h0,  6'b000000, 0, 0, 32'h66};

    // Reset state
    rst_ = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 6'b000000, 0, 0, 32'h0);
    rst_ = 1'b1;

    // Table vectors
    for (int i = 0; i < 14; i++) begin
      step();
      drive(vecs[i].id, vecs[i].ex, vecs[i].mcs, vecs[i].mcn, vecs[i].fr, vecs[i].fpc);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush,
              vecs[i].e_busy, vecs[i].e_pc);
    end

    // Multi-cycle N=5: stall in cycles 0..4, busy in 1..4, clear in 5
    step(); drive(0, 0, 1, 6'd5, 0, 0); #1;
    chk_all("mc5.c0", 6'b001111, 0, 0, 32'h66);
    for (int c = 1; c <= 4; c++) begin
      step(); drive(0, 0, (c == 2), 6'd7, 0, 0); #1;  // a restart in MCYC is ignored
      chk_all($sformatf("mc5.c%0d", c), 6'b001111, 0, 1, 32'h66);
    end
    step(); drive(0, 0, 0, 0, 0, 0); #1;
    chk_all("mc5.c5", 6'b000000, 0, 0, 32'h66);

    // Flush abort during MCYC
    step(); drive(0, 0, 1, 6'd5, 0, 0); #1;
    step(); drive(0, 0, 0, 0, 0, 0); #1;
    chk_all("abort.busy", 6'b001111, 0, 1, 32'h66);
    step(); drive(0, 0, 0, 0, 1, 32'h180); #1;
    chk_all("abort.t", 6'b000000, 0, 1, 32'h66);
    step(); drive(0, 0, 0, 0, 0, 0); #1;
    chk_all("abort.t1", 6'b000000, 1, 0, 32'h180);
    step(); #1;
    chk_all("abort.t2", 6'b000000, 0, 0, 32'h180);

    // Back-to-back flush
    step(); drive(0, 0, 0, 0, 1, 32'h100); #1;
    step(); drive(0, 0, 0, 0, 1, 32'h200); #1;
    chk_all("b2b.t1", 6'b000000, 1, 0, 32'h100);
    step(); drive(0, 0, 0, 0, 0, 0); #1;
    chk_all("b2b.t2", 6'b000000, 1, 0, 32'h200);
    step(); #1;
    chk_all("b2b.t3", 6'b000000, 0, 0, 32'h200);

    // Reset mid-MCYC with the countdown at 3 (N=6 loads 4, then 3)
    step(); drive(0, 0, 1, 6'd6, 0, 0); #1;
    step(); drive(0, 0, 0, 0, 0, 0); #1;
    step(); #1;
    chk_all("rstmc.pre", 6'b001111, 0, 1, 32'h200);
    rst_ = 1'b0;
    id_stallreq = 1'b1;
    #1;
    chk_all("rstmc.in", 6'b000000, 0, 0, 32'h0);
    step(); rst_ = 1'b1; id_stallreq = 1'b0; #1;
    chk_all("rstmc.rel", 6'b000000, 0, 0, 32'h0);
    step(); #1;
    chk_all("rstmc.run", 6'b000000, 0, 0, 32'h0);

`ifdef PIPE_CTRL_STALL_CNT_EN
    chk("cnt.reset", stall_cycles, 32'd0);
    for (int c = 0; c < 7; c++) begin
      step(); drive(0, 1, 0, 0, 0, 0); #1;
    end
    step(); drive(0, 0, 0, 0, 0, 0); #1;
    chk("cnt.seven", stall_cycles, 32'd7);
    step(); drive(1, 1, 0, 0, 1, 32'h40); #1;
    chk("cnt.prio_stall", 32'(stall), 32'd0);
    chk("cnt.hold", stall_cycles, 32'd7);
    step(); drive(0, 0, 0, 0, 0, 0); #1;
    chk("cnt.flush", 32'(flush), 32'd1);
    chk("cnt.cleared", stall_cycles, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline control unit for the five-stage openMIPS core.
- Collects stall requests from the ID stage (load-use hazard) and the EX stage (multi-cycle ops such as mult/div).
- Sequences multi-cycle EX operations with an internal countdown.
- Schedules pipeline flushes, with a redirect PC, from exception or branch-redirect requests.
- Drives the per-stage stall vector to PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
CNT_W, 6, width of multi-cycle length field; max multi-cycle op length 2^CNT_W-1 cycles
PC_W, 32, width of redirect PC

Ports:
clk  input  1  core clock
rst_  input  1  asynchronous active-low reset
id_stallreq  input  1  ID load-use hazard; combinational stall request, current cycle
ex_stallreq  input  1  EX generic stall request, current cycle
ex_mc_start  input  1  one-cycle pulse: EX begins a multi-cycle op
ex_mc_cycles  input  CNT_W  total stall cycles for the op; sampled with ex_mc_start
flush_req  input  1  flush request (exception/redirect), current cycle
flush_pc  input  PC_W  redirect target; sampled with flush_req
stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
flush  output  1  registered one-cycle flush pulse to all pipeline registers
new_pc  output  PC_W  redirect PC; valid when flush=1
mc_busy  output  1  high while in MCYC state

Behaviour:
Interface:
- Single clock domain on clk.
- Reset is asynchronous, active-low on rst_.
- While rst_=0: state=RUN, counter=0, flush=0, new_pc=0, stall=0, mc_busy=0.

States: RUN, MCYC, FLUSH.

Stall vector encoding, combinational from state and inputs:
- flush_req=1 in any state -> stall=6'b000000. Flush has the highest priority.
- Otherwise, state MCYC, or (RUN and ex_mc_start and ex_mc_cycles!=0) -> 6'b001111.
- Otherwise ex_stallreq -> 6'b001111.
- Otherwise id_stallreq -> 6'b000111.
- Otherwise 6'b000000.
- In FLUSH state, id_stallreq and ex_stallreq are ignored: stall=0.

Transitions:
- RUN:
  - flush_req -> FLUSH; latch new_pc<=flush_pc.
  - Else ex_mc_start with N=ex_mc_cycles>0:
    - N=1: stall for this cycle only; stay RUN.
    - N>1: counter<=N-2; -> MCYC.
  - ex_mc_start with N=0: ignored, no stall.
- MCYC:
  - flush_req -> FLUSH. Aborts the op; counter<=0; latch new_pc.
  - Else if counter==0 -> RUN.
  - Else counter<=counter-1.
  - Result: stall is held for exactly N consecutive cycles, counting the start cycle.
  - ex_mc_start while in MCYC is ignored.
- FLUSH:
  - flush=1 and mc_busy=0 for this cycle.
  - flush_req again -> stay FLUSH; re-latch new_pc. flush stays 1 for another cycle.
  - Else -> RUN.

Latency and output rules:
- flush_req at cycle t -> flush=1 with new_pc=flush_pc(t) at cycle t+1.
- flush is registered and is 1 exactly in the FLUSH state.
- new_pc holds its last value when flush=0.
- mc_busy = (state==MCYC), registered.

Reset mid-operation: assertion of rst_ in any state returns to RUN immediately. The multi-cycle op and any pending flush are discarded.

Optional Feature:
Macro: PIPE_CTRL_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [31:0].
  - Increments by 1 every cycle that stall[0]=1.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared to 0 on reset, and on the cycle flush=1.
- Undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset: rst_=0 mid-MCYC (counter=3) -> all outputs 0 immediately. After release, stall=0 and state RUN.
- Load-use: id_stallreq=1 for 1 cycle, no other requests -> stall=6'b000111 that cycle only. Next cycle stall=0.
- Multi-cycle: ex_mc_start=1, ex_mc_cycles=5 at cycle 10 -> stall=6'b001111 at cycles 10-14, stall=0 at cycle 15, mc_busy=1 at cycles 11-14. Also cover N=1 (1 stall cycle, mc_busy never 1) and N=0 (no stall).
- Flush abort: during MCYC, flush_req=1 with flush_pc=32'h0000_0180 at cycle t:
  - stall=0 at cycle t.
  - flush=1 and new_pc=32'h180 at t+1.
  - RUN at t+2, with no residual stall.
- Back-to-back flush: flush_req at t (pc 32'h100) and t+1 (pc 32'h200):
  - flush=1 at t+1 (new_pc 32'h100) and t+2 (new_pc 32'h200).
  - flush=0 at t+3.
- Priority, with PIPE_CTRL_STALL_CNT_EN defined: id_stallreq, ex_stallreq and flush_req all 1 in the same cycle -> stall=0.
  - Separately, 7 stalled cycles -> stall_cycles=7.
  - A following flush clears stall_cycles to 0.
